// File: rtl/rpc_echo_responder.sv
// RPC echo responder: buffers inbound requests, holds each for PROC_LATENCY cycles, returns it as a response.
// Optional request/drop counters are built when RPC_ECHO_RESPONDER_STATS_EN is defined.
package rpc_echo_pkg;
  typedef enum logic [1:0] {
    rpcReq  = 2'd0,
    rpcResp = 2'd1,
    rpcNack = 2'd2,
    rpcRsvd = 2'd3
  } rpc_type_e;

  typedef struct packed {
    rpc_type_e   req_type;
    logic [5:0]  msg_id;
  } rpc_ctl_t;

  typedef struct packed {
    rpc_ctl_t    ctl;
    logic [7:0]  len;
  } rpc_hdr_t;

  typedef struct packed {
    rpc_hdr_t    hdr;
    logic [31:0] payload;
  } rpc_data_t;

  typedef struct packed {
    rpc_data_t   rpc_data;
    logic [7:0]  flow_id;
  } RpcIf;
endpackage

module rpc_echo_responder
  import rpc_echo_pkg::*;
#(
  parameter logic [31:0] NIC_ID       = 32'h0,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned PROC_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rpc_valid_in,
  input  RpcIf        rpc_in,
  output logic        rpc_ready_out,
  output logic        rpc_valid_out,
  output RpcIf        rpc_out,
  input  logic        rpc_ready_in,
  output logic [31:0] req_cnt_out,
  output logic [31:0] drop_cnt_out
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned OW = PW + 1;
  localparam int unsigned LW = (PROC_LATENCY > 1) ? $clog2(PROC_LATENCY) : 1;
  localparam logic [OW-1:0] FULL_OCC = OW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LAT_LOAD = LW'(PROC_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, PROC, SEND} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [OW-1:0] occ_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  RpcIf          mem_q [FIFO_DEPTH];
  RpcIf          work_q;
  RpcIf          head_resp;
  logic          is_req, push, pop;
  logic          unused_nic_id;

  // NIC_ID only tags trace output in simulation models; nothing in hardware depends on it.
  assign unused_nic_id = ^NIC_ID;

  assign is_req        = (rpc_in.rpc_data.hdr.ctl.req_type == rpcReq);
  assign rpc_ready_out = (occ_q != FULL_OCC);
  assign push          = rpc_valid_in && rpc_ready_out && is_req;
  assign rpc_out       = work_q;

  always_comb begin
    head_resp = mem_q[rd_ptr_q];
    head_resp.rpc_data.hdr.ctl.req_type = rpcResp;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rpc_in;
  end

  // Occupancy is read before the pop, so a popped slot becomes available one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      occ_q <= occ_q + OW'(1);
      else if (pop && !push) occ_q <= occ_q - OW'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    pop           = 1'b0;
    rpc_valid_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (occ_q != '0) begin
          pop     = 1'b1;
          lat_d   = LAT_LOAD;
          state_d = PROC;
        end
      end
      PROC: begin
        if (lat_q == '0) state_d = SEND;
        else             lat_d   = lat_q - LW'(1);
      end
      SEND: begin
        rpc_valid_out = 1'b1;
        if (rpc_ready_in) begin
          if (occ_q != '0) begin
            pop     = 1'b1;
            lat_d   = LAT_LOAD;
            state_d = PROC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The response is formed at pop time so rpc_out is already stable when SEND begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lat_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      if (pop) work_q <= head_resp;
    end
  end

`ifdef RPC_ECHO_RESPONDER_STATS_EN
  logic [31:0] req_cnt_q, drop_cnt_q;
  logic        drop;

  assign drop = rpc_valid_in && (!is_req || !rpc_ready_out);

  always_ff @(posedge clk) begin
    if (reset) begin
      req_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push && (req_cnt_q != 32'hFFFF_FFFF))  req_cnt_q  <= req_cnt_q + 32'd1;
      if (drop && (drop_cnt_q != 32'hFFFF_FFFF)) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign req_cnt_out  = req_cnt_q;
  assign drop_cnt_out = drop_cnt_q;
`else
  assign req_cnt_out  = 32'h0;
  assign drop_cnt_out = 32'h0;
`endif

endmodule

// File: tb/tb_rpc_echo_responder.sv
// Directed bench for rpc_echo_responder: vector table of single transactions plus
// hand-written backpressure, overflow, wrap and mid-operation reset sequences.
module tb_rpc_echo_responder;
  import rpc_echo_pkg::*;

`ifdef RPC_ECHO_RESPONDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int LAT_EDGES = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        rpc_valid_in;
  RpcIf        rpc_in;
  logic        rpc_ready_out;
  logic        rpc_valid_out;
  RpcIf        rpc_out;
  logic        rpc_ready_in;
  logic [31:0] req_cnt_out;
  logic [31:0] drop_cnt_out;

  int errors = 0;
  int checks = 0;
  int exp_req = 0;
  int exp_drop = 0;
  int prod_i, prod_g, n, seen;

  typedef struct {
    rpc_type_e   typ;
    logic [5:0]  msg;
    logic [7:0]  len;
    logic [31:0] pay;
    logic [7:0]  flow;
    bit          exp_resp;
    rpc_type_e   exp_typ;
  } vec_t;

  vec_t vecs [6];

  rpc_echo_responder #(
    .NIC_ID      (32'h0),
    .FIFO_DEPTH  (8),
    .PROC_LATENCY(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rpc_valid_in (rpc_valid_in),
    .rpc_in       (rpc_in),
    .rpc_ready_out(rpc_ready_out),
    .rpc_valid_out(rpc_valid_out),
    .rpc_out      (rpc_out),
    .rpc_ready_in (rpc_ready_in),
    .req_cnt_out  (req_cnt_out),
    .drop_cnt_out (drop_cnt_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int cnt);
    cnt = 0;
    while (!rpc_valid_out && cnt < budget) begin
      tick();
      cnt++;
    end
  endtask

  function automatic RpcIf mk(input rpc_type_e t, input logic [5:0] m, input logic [7:0] l,
                              input logic [31:0] p, input logic [7:0] f);
    RpcIf r;
    r.rpc_data.hdr.ctl.req_type = t;
    r.rpc_data.hdr.ctl.msg_id   = m;
    r.rpc_data.hdr.len          = l;
    r.rpc_data.payload          = p;
    r.flow_id                   = f;
    return r;
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, "_req_cnt"},  64'(req_cnt_out),  STATS ? 64'(exp_req)  : 64'd0);
    chk({tag, "_drop_cnt"}, 64'(drop_cnt_out), STATS ? 64'(exp_drop) : 64'd0);
  endtask

  initial begin
    vecs[0] = '{rpcReq,  6'h01, 8'h10, 32'hDEAD_BEEF, 8'd3,   1'b1, rpcResp};
    vecs[1] = '{rpcReq,  6'h3F, 8'hFF, 32'h0000_0000, 8'hFF,  1'b1, rpcResp};
    vecs[2] = '{rpcResp, 6'h05, 8'h20, 32'h1234_5678, 8'd7,   1'b0, rpcResp};
    vecs[3] = '{rpcReq,  6'h2A, 8'h00, 32'hFFFF_FFFF, 8'd0,   1'b1, rpcResp};
    vecs[4] = '{rpcNack, 6'h11, 8'h08, 32'hCAFE_F00D, 8'd9,   1'b0, rpcResp};
    vecs[5] = '{rpcRsvd, 6'h00, 8'h01, 32'h0BAD_0001, 8'd12,  1'b0, rpcResp};

    reset        = 1'b1;
    rpc_valid_in = 1'b0;
    rpc_in       = '0;
    rpc_ready_in = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_ready",   64'(rpc_ready_out), 64'd1);
    chk("rst_valid",   64'(rpc_valid_out), 64'd0);
    chk("rst_rpc_out", 64'(rpc_out),       64'd0);
    chk_counters("rst");

    // Table-driven single transactions
    for (int v = 0; v < 6; v++) begin
      rpc_ready_in = 1'b1;
      rpc_in       = mk(vecs[v].typ, vecs[v].msg, vecs[v].len, vecs[v].pay, vecs[v].flow);
      rpc_valid_in = 1'b1;
      tick();
      rpc_valid_in = 1'b0;
      if (vecs[v].exp_resp) begin
        exp_req++;
        wait_valid(20, n);
        chk($sformatf("v%0d_latency", v), 64'(n), 64'(LAT_EDGES));
        chk($sformatf("v%0d_valid", v), 64'(rpc_valid_out), 64'd1);
        chk($sformatf("v%0d_resp", v), 64'(rpc_out),
            64'(mk(vecs[v].exp_typ, vecs[v].msg, vecs[v].len, vecs[v].pay, vecs[v].flow)));
        tick();
        chk($sformatf("v%0d_one_cycle", v), 64'(rpc_valid_out), 64'd0);
      end else begin
        exp_drop++;
        seen = 0;
        repeat (12) begin
          tick();
          if (rpc_valid_out) seen++;
        end
        chk($sformatf("v%0d_no_resp", v), 64'(seen), 64'd0);
      end
      chk_counters($sformatf("v%0d", v));
      chk($sformatf("v%0d_ready", v), 64'(rpc_ready_out), 64'd1);
    end

    // Backpressure: response must hold for 10 stalled cycles
    rpc_ready_in = 1'b0;
    rpc_in       = mk(rpcReq, 6'h15, 8'h44, 32'h5555_AAAA, 8'd9);
    rpc_valid_in = 1'b1;
    tick();
    rpc_valid_in = 1'b0;
    exp_req++;
    wait_valid(20, n);
    chk("bp_latency", 64'(n), 64'(LAT_EDGES));
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_valid_%0d", c), 64'(rpc_valid_out), 64'd1);
      chk($sformatf("bp_data_%0d", c), 64'(rpc_out),
          64'(mk(rpcResp, 6'h15, 8'h44, 32'h5555_AAAA, 8'd9)));
      tick();
    end
    rpc_ready_in = 1'b1;
    tick();
    seen = 0;
    repeat (10) begin
      if (rpc_valid_out) seen++;
      tick();
    end
    chk("bp_single_resp", 64'(seen), 64'd0);
    chk_counters("bp");

    // Overflow: 10 back-to-back requests with the output stalled
    rpc_ready_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rpc_in       = mk(rpcReq, 6'(i), 8'(i), 32'h1000 + 32'(i), 8'(100 + i));
      rpc_valid_in = 1'b1;
      chk($sformatf("ovf_ready_%0d", i), 64'(rpc_ready_out), (i < 9) ? 64'd1 : 64'd0);
      if (i < 9) exp_req++;
      else       exp_drop++;
      tick();
    end
    rpc_valid_in = 1'b0;
    chk("ovf_full", 64'(rpc_ready_out), 64'd0);
    chk_counters("ovf");
    rpc_ready_in = 1'b1;
    for (int k = 0; k < 9; k++) begin
      wait_valid(20, n);
      chk($sformatf("ovf_to_%0d", k), 64'(n < 20), 64'd1);
      chk($sformatf("ovf_resp_%0d", k), 64'(rpc_out),
          64'(mk(rpcResp, 6'(k), 8'(k), 32'h1000 + 32'(k), 8'(100 + k))));
      tick();
    end
    seen = 0;
    repeat (12) begin
      if (rpc_valid_out) seen++;
      tick();
    end
    chk("ovf_extra_resp", 64'(seen), 64'd0);
    chk("ovf_ready_after", 64'(rpc_ready_out), 64'd1);

    // Pointer wrap: 20 requests fed as fast as the block accepts them
    rpc_ready_in = 1'b1;
    fork
      begin
        prod_i = 0;
        prod_g = 0;
        while (prod_i < 20 && prod_g < 2000) begin
          rpc_in       = mk(rpcReq, 6'(prod_i), 8'(prod_i), 32'hA000_0000 + 32'(prod_i), 8'(prod_i));
          rpc_valid_in = 1'b1;
          if (rpc_ready_out) prod_i++;
          tick();
          prod_g++;
        end
        rpc_valid_in = 1'b0;
      end
      begin
        for (int k = 0; k < 20; k++) begin
          wait_valid(200, n);
          chk($sformatf("wrap_to_%0d", k), 64'(n < 200), 64'd1);
          chk($sformatf("wrap_flow_%0d", k), 64'(rpc_out.flow_id), 64'(k));
          tick();
        end
      end
    join
    exp_req += 20;
    chk_counters("wrap");

    // Reset while in PROC with three entries queued
    rpc_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rpc_in       = mk(rpcReq, 6'h20, 8'h02, 32'h7000 + 32'(i), 8'(50 + i));
      rpc_valid_in = 1'b1;
      tick();
    end
    rpc_valid_in = 1'b0;
    chk("mid_full_not", 64'(rpc_ready_out), 64'd1);
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    exp_req  = 0;
    exp_drop = 0;
    chk("mid_ready",   64'(rpc_ready_out), 64'd1);
    chk("mid_valid",   64'(rpc_valid_out), 64'd0);
    chk("mid_rpc_out", 64'(rpc_out),       64'd0);
    chk_counters("mid");
    rpc_ready_in = 1'b1;
    seen = 0;
    repeat (30) begin
      tick();
      if (rpc_valid_out) seen++;
    end
    chk("mid_no_resp", 64'(seen), 64'd0);
    chk_counters("mid_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rpc_echo_responder.md
RPC_ECHO_RESPONDER -- requirements
Module: rpc_echo_responder

Interface
REQ-001 SHALL have parameter NIC_ID, default 32'h0, the NIC index used in trace messages.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, the request buffer depth; it must be a power of two and at least 2.
REQ-003 SHALL have parameter PROC_LATENCY, default 4, the processing cycles per request; it must be at least 1.
REQ-004 SHALL have port clk, input, 1, the clock.
REQ-005 SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-006 SHALL have port rpc_valid_in, input, 1, which marks an inbound RPC from the deserializer as valid.
REQ-007 SHALL have port rpc_in, input, RpcIf, the inbound RPC (rpc_data, flow_id).
REQ-008 SHALL have port rpc_ready_out, output, 1, which is high when the block can accept an inbound RPC.
REQ-009 SHALL have port rpc_valid_out, output, 1, which marks the response RPC to the serializer as valid.
REQ-010 SHALL have port rpc_out, output, RpcIf, the response RPC.
REQ-011 SHALL have port rpc_ready_in, input, 1, which is high when the downstream serializer can accept a response.
REQ-012 SHALL have port req_cnt_out, output, 32, the count of accepted requests.
REQ-013 SHALL have port drop_cnt_out, output, 32, the count of dropped inbound RPCs.

Function
REQ-014 SHALL drive rpc_ready_out combinationally as (occupancy != FIFO_DEPTH); a cycle in which an entry is popped does not free a slot in that same cycle.
REQ-015 SHALL enqueue rpc_in when rpc_valid_in && rpc_ready_out && rpc_in.rpc_data.hdr.ctl.req_type == rpcReq.
REQ-016 SHALL drop an inbound RPC and increment drop_cnt_out in either case: rpc_valid_in with req_type != rpcReq (regardless of occupancy), or rpc_valid_in with a request while the FIFO is full.
REQ-017 SHALL use a FIFO with occupancy counter 0..FIFO_DEPTH and log2(FIFO_DEPTH)-bit read/write pointers that wrap modulo FIFO_DEPTH; same-cycle push and pop leave occupancy unchanged.
REQ-018 SHALL implement an FSM with three states: IDLE, PROC and SEND.
REQ-019 SHALL, in IDLE with occupancy > 0, pop the FIFO head into a working register, load the latency counter with PROC_LATENCY-1, and go to PROC.
REQ-020 SHALL, in PROC, go to SEND when the counter is 0 and otherwise decrement it, so that PROC lasts exactly PROC_LATENCY cycles.
REQ-021 SHALL, in SEND, assert rpc_valid_out and hold rpc_out stable until a cycle with rpc_ready_in high.
REQ-022 SHALL, on that SEND handshake, pop the next entry and go to PROC if occupancy > 0, and otherwise go to IDLE.
REQ-023 SHALL form the response as the working-register copy, with rpc_data.hdr.ctl.req_type set to rpcResp, all other rpc_data fields echoed unchanged, and flow_id unchanged.
REQ-024 SHALL produce the first rpc_valid_out exactly PROC_LATENCY+1 clock edges after the accepting edge, given an empty FIFO and the FSM in IDLE.
REQ-025 SHALL sustain at most one response per PROC_LATENCY+1 cycles.
REQ-026 SHALL emit responses in strict acceptance order.
REQ-027 SHALL saturate both counters at 32'hFFFFFFFF without wrapping.

Reset
REQ-028 SHALL, while reset is high at a clock edge, clear occupancy and pointers, set the FSM to IDLE, set rpc_valid_out to 0, set rpc_out to all zeros, set both counters to 0, and discard any in-flight response.
REQ-029 SHALL drive rpc_ready_out to 1 in the first cycle after reset deasserts.
REQ-030 SHALL flush all buffered and in-flight requests on reset during PROC or SEND and emit no response for them.

Configuration
REQ-031 SHALL, with RPC_ECHO_RESPONDER_STATS_EN defined, implement req_cnt_out and drop_cnt_out as specified above.
REQ-032 SHALL, without RPC_ECHO_RESPONDER_STATS_EN, keep both counter ports, tie them to 32'h0, and instantiate no counter registers; drop behaviour is otherwise unchanged.

Verification
REQ-033 SHALL cover single request: one rpcReq with flow_id=3 and rpc_ready_in=1, with PROC_LATENCY=4 -> rpc_valid_out high for 1 cycle, 5 edges after acceptance, req_type=rpcResp, flow_id=3, other fields echoed, req_cnt_out=1.
REQ-034 SHALL cover backpressure: rpc_ready_in=0 for 10 cycles during SEND -> rpc_valid_out held high and rpc_out stable throughout; exactly one response after rpc_ready_in rises.
REQ-035 SHALL cover overflow: 10 back-to-back requests, rpc_ready_in=0, FIFO_DEPTH=8 -> the first 9 accepted (8 buffered plus 1 in the working register), rpc_ready_out=0 afterwards, drop_cnt_out=1, then 9 responses in order after release.
REQ-036 SHALL cover a non-request input: rpcResp on rpc_in -> not enqueued, drop_cnt_out increments by 1, no rpc_valid_out.
REQ-037 SHALL cover reset mid-operation: reset asserted in PROC with 3 entries queued -> no responses afterwards, rpc_ready_out=1, counters 0.
REQ-038 SHALL cover pointer wrap: 20 sequential requests with distinct flow_id values 0..19 -> 20 responses with flow_id 0..19 in order.
